// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared types and sizing for the branch resolve controller and its update FIFO.
package branch_resolve_ctrl_pkg;

  localparam int unsigned UPD_FIFO_DEPTH = 4;
  localparam int unsigned UpdPtrW        = $clog2(UPD_FIFO_DEPTH);
  localparam int unsigned UpdCntW        = $clog2(UPD_FIFO_DEPTH + 1);

  typedef enum logic [0:0] {
    StIdle,
    StRedir
  } brc_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
  } upd_entry_t;

endpackage

// File: rtl/branch_upd_fifo.sv
// Predictor update FIFO: two ordered writes and one read per cycle; writes that find
// no room (after this cycle's read) are dropped.
module branch_upd_fifo
  import branch_resolve_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push0,
  input  upd_entry_t         wdata0,
  input  logic               push1,
  input  upd_entry_t         wdata1,
  input  logic               pop,
  output upd_entry_t         rdata,
  output logic               empty,
  output logic [UpdCntW-1:0] count,
  output logic [1:0]         acc_cnt
);

  upd_entry_t               mem_q [UPD_FIFO_DEPTH];
  logic [UpdPtrW-1:0]       wptr_q, rptr_q;
  logic [UpdCntW-1:0]       count_q, count_d, space;
  logic                     pop_ok, acc0, acc1;

  always_comb begin
    pop_ok  = pop && (count_q != '0);
    space   = UpdCntW'(UPD_FIFO_DEPTH) - count_q + UpdCntW'(pop_ok);
    acc0    = push0 && (space != '0);
    // Second write needs a slot beyond the one the first write may have taken.
    acc1    = push1 && (space > UpdCntW'(acc0));
    count_d = count_q + UpdCntW'(acc0) + UpdCntW'(acc1) - UpdCntW'(pop_ok);
    acc_cnt = {1'b0, acc0} + {1'b0, acc1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < UPD_FIFO_DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (acc0) mem_q[wptr_q] <= wdata0;
      if (acc1) mem_q[wptr_q + UpdPtrW'(acc0)] <= wdata1;
      wptr_q  <= wptr_q + UpdPtrW'(acc0) + UpdPtrW'(acc1);
      rptr_q  <= rptr_q + UpdPtrW'(pop_ok);
      count_q <= count_d;
    end
  end

  assign rdata = mem_q[rptr_q];
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution: picks the oldest mispredict, drives frontend redirect and backend
// flush, and queues predictor updates. Optional statistics under BRANCH_STAT_EN.
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  res_valid_p,
  input  logic [1:0]  res_is_branch_p,
  input  logic [1:0]  res_flush_p,
  input  logic [1:0]  res_taken_p,
  input  logic [31:0] res_pc_p0,
  input  logic [31:0] res_pc_p1,
  input  logic [31:0] res_addr_p0,
  input  logic [31:0] res_addr_p1,
  input  logic        ext_flush,
  output logic        res_stall,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic        flush_o,
  output logic        upd_valid,
  output logic [31:0] upd_pc,
  output logic [31:0] upd_target,
  output logic        upd_taken,
  input  logic        upd_ready,
  output logic [31:0] stat_branch_cnt,
  output logic [31:0] stat_mispred_cnt
);

  brc_state_e         state_q, state_d;
  logic [31:0]        redirect_pc_q, redirect_pc_d;
  logic               flush_q, flush_d;
  logic               accept, sel0, sel1, mispred, push0, push1, empty;
  upd_entry_t         wdata0, wdata1, head;
  logic [UpdCntW-1:0] count;
  logic [1:0]         acc_cnt;

  // Results are only trusted when idle and not being flushed from commit.
  assign accept  = (state_q == StIdle) && !ext_flush;
  assign sel0    = accept && res_valid_p[0] && res_flush_p[0];
  assign sel1    = accept && !sel0 && res_valid_p[1] && res_flush_p[1];
  assign mispred = sel0 || sel1;
  assign push0   = accept && res_valid_p[0] && res_is_branch_p[0];
  assign push1   = accept && !sel0 && res_valid_p[1] && res_is_branch_p[1];

  assign wdata0 = '{pc: res_pc_p0, target: res_addr_p0, taken: res_taken_p[0]};
  assign wdata1 = '{pc: res_pc_p1, target: res_addr_p1, taken: res_taken_p[1]};

  always_comb begin
    state_d       = state_q;
    redirect_pc_d = redirect_pc_q;
    flush_d       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mispred) begin
          state_d       = StRedir;
          redirect_pc_d = sel0 ? res_addr_p0 : res_addr_p1;
          flush_d       = 1'b1;
        end
      end
      StRedir: begin
        if (redirect_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (ext_flush) begin
      state_d = StIdle;
      flush_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      redirect_pc_q <= '0;
      flush_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      redirect_pc_q <= redirect_pc_d;
      flush_q       <= flush_d;
    end
  end

  branch_upd_fifo u_upd_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push0   (push0),
    .wdata0  (wdata0),
    .push1   (push1),
    .wdata1  (wdata1),
    .pop     (upd_ready),
    .rdata   (head),
    .empty   (empty),
    .count   (count),
    .acc_cnt (acc_cnt)
  );

  assign res_stall      = (count > UpdCntW'(2)) || (state_q == StRedir);
  assign redirect_valid = (state_q == StRedir);
  assign redirect_pc    = redirect_pc_q;
  assign flush_o        = flush_q;
  assign upd_valid      = !empty;
  assign upd_pc         = empty ? '0 : head.pc;
  assign upd_target     = empty ? '0 : head.target;
  assign upd_taken      = !empty && head.taken;

`ifdef BRANCH_STAT_EN
  logic [31:0] stat_branch_q, stat_mispred_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branch_q  <= '0;
      stat_mispred_q <= '0;
    end else begin
      stat_branch_q  <= stat_branch_q + 32'(acc_cnt);
      stat_mispred_q <= stat_mispred_q + 32'(mispred);
    end
  end

  assign stat_branch_cnt  = stat_branch_q;
  assign stat_mispred_cnt = stat_mispred_q;
`else
  logic unused_acc_cnt;
  assign unused_acc_cnt   = ^acc_cnt;
  assign stat_branch_cnt  = '0;
  assign stat_mispred_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_branch_resolve_ctrl;
  import branch_resolve_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  res_valid_p, res_is_branch_p, res_flush_p, res_taken_p;
  logic [31:0] pcs [2];
  logic [31:0] addrs [2];
  logic        ext_flush, redirect_ready, upd_ready;
  logic        res_stall, redirect_valid, flush_o, upd_valid, upd_taken;
  logic [31:0] redirect_pc, upd_pc, upd_target, stat_branch_cnt, stat_mispred_cnt;

  always #5 clk = ~clk;

  branch_resolve_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .res_valid_p      (res_valid_p),
    .res_is_branch_p  (res_is_branch_p),
    .res_flush_p      (res_flush_p),
    .res_taken_p      (res_taken_p),
    .res_pc_p0        (pcs[0]),
    .res_pc_p1        (pcs[1]),
    .res_addr_p0      (addrs[0]),
    .res_addr_p1      (addrs[1]),
    .ext_flush        (ext_flush),
    .res_stall        (res_stall),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .redirect_ready   (redirect_ready),
    .flush_o          (flush_o),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_target       (upd_target),
    .upd_taken        (upd_taken),
    .upd_ready        (upd_ready),
    .stat_branch_cnt  (stat_branch_cnt),
    .stat_mispred_cnt (stat_mispred_cnt)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
  } ent_t;

  ent_t        mq[$];
  bit          m_redir, m_flush;
  logic [31:0] m_rpc, m_bcnt, m_mcnt;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_redir = 0;
    m_flush = 0;
    m_rpc   = '0;
    m_bcnt  = '0;
    m_mcnt  = '0;
  endtask

  // One clock edge of the reference behaviour, applied to the inputs now on the pins.
  task automatic model_step();
    bit   mis;
    ent_t e;
    mis = 0;
    if (mq.size() != 0 && upd_ready) e = mq.pop_front();
    if (!m_redir && !ext_flush) begin
      for (int p = 0; p < 2; p++) begin
        if (!mis && res_valid_p[p]) begin
          if (res_is_branch_p[p] && mq.size() < UPD_FIFO_DEPTH) begin
            e.pc = pcs[p];
            e.target = addrs[p];
            e.taken = res_taken_p[p];
            mq.push_back(e);
            m_bcnt++;
          end
          if (res_flush_p[p]) begin
            mis = 1;
            m_rpc = addrs[p];
            m_mcnt++;
          end
        end
      end
    end
    m_flush = mis;
    if (ext_flush) m_redir = 0;
    else if (m_redir) m_redir = !redirect_ready;
    else m_redir = mis;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".rv"}, 32'(redirect_valid), 32'(m_redir));
    if (m_redir) check({tag, ".rpc"}, redirect_pc, m_rpc);
    check({tag, ".flush"}, 32'(flush_o), 32'(m_flush));
    check({tag, ".stall"}, 32'(res_stall), 32'(mq.size() > 2 || m_redir));
    check({tag, ".uv"}, 32'(upd_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      check({tag, ".upc"}, upd_pc, mq[0].pc);
      check({tag, ".utgt"}, upd_target, mq[0].target);
      check({tag, ".utk"}, 32'(upd_taken), 32'(mq[0].taken));
    end
`ifdef BRANCH_STAT_EN
    check({tag, ".bcnt"}, stat_branch_cnt, m_bcnt);
    check({tag, ".mcnt"}, stat_mispred_cnt, m_mcnt);
`else
    check({tag, ".bcnt0"}, stat_branch_cnt, 32'd0);
    check({tag, ".mcnt0"}, stat_mispred_cnt, 32'd0);
`endif
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic clear_res();
    res_valid_p = '0;
    res_is_branch_p = '0;
    res_flush_p = '0;
    res_taken_p = '0;
    for (int p = 0; p < 2; p++) begin
      pcs[p] = '0;
      addrs[p] = '0;
    end
    ext_flush = 0;
  endtask

  task automatic set_pipe(input int p, input bit br, input bit fl, input bit tk,
                          input logic [31:0] pc, input logic [31:0] addr);
    res_valid_p[p] = 1'b1;
    res_is_branch_p[p] = br;
    res_flush_p[p] = fl;
    res_taken_p[p] = tk;
    pcs[p] = pc;
    addrs[p] = addr;
  endtask

  task automatic rand_res();
    for (int p = 0; p < 2; p++) begin
      res_valid_p[p] = 1'($urandom);
      res_is_branch_p[p] = ($urandom_range(0, 3) != 0);
      res_flush_p[p] = ($urandom_range(0, 5) == 0);
      res_taken_p[p] = 1'($urandom);
      pcs[p] = $urandom & 32'hFFFF_FFFC;
      addrs[p] = $urandom & 32'hFFFF_FFFC;
    end
    ext_flush = ($urandom_range(0, 19) == 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".rv"}, 32'(redirect_valid), 32'd0);
    check({tag, ".rpc"}, redirect_pc, 32'd0);
    check({tag, ".flush"}, 32'(flush_o), 32'd0);
    check({tag, ".uv"}, 32'(upd_valid), 32'd0);
    check({tag, ".upc"}, upd_pc, 32'd0);
    check({tag, ".utgt"}, upd_target, 32'd0);
    check({tag, ".stall"}, 32'(res_stall), 32'd0);
    check({tag, ".bcnt"}, stat_branch_cnt, 32'd0);
    check({tag, ".mcnt"}, stat_mispred_cnt, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    clear_res();
    redirect_ready = 0;
    upd_ready = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Pipe 0 mispredicts: pipe 1 is younger and must be discarded.
    set_pipe(0, 1, 1, 1, 32'h1C00_00F0, 32'h1C00_0100);
    set_pipe(1, 1, 0, 0, 32'h1C00_00F8, 32'h1C00_0200);
    step("r020");
    check("r020.pc_const", redirect_pc, 32'h1C00_0100);
    check("r020.flush_const", 32'(flush_o), 32'd1);
    clear_res();
    redirect_ready = 1;
    upd_ready = 1;
    step("r020.ack");
    redirect_ready = 0;
    step("r020.drain");

    // Pipe 0 correct, pipe 1 mispredicts: both updates enqueue in order.
    upd_ready = 0;
    set_pipe(0, 1, 0, 0, 32'h1C00_0300, 32'h1C00_0308);
    set_pipe(1, 1, 1, 1, 32'h1C00_0304, 32'h1C00_0208);
    step("r021");
    check("r021.pc_const", redirect_pc, 32'h1C00_0208);
    clear_res();

    // Redirect held off for 5 cycles while wrong-path results arrive.
    for (int i = 0; i < 5; i++) begin
      rand_res();
      ext_flush = 0;
      step("r022");
    end
    check("r022.still_valid", 32'(redirect_valid), 32'd1);
    clear_res();

    // Commit flush while redirect pending: no flush pulse, FIFO kept.
    ext_flush = 1;
    step("r023");
    check("r023.rv_const", 32'(redirect_valid), 32'd0);
    clear_res();
    upd_ready = 1;
    step("r023.d0");
    step("r023.d1");

    // Backpressure: 5 branches offered with the predictor stalled.
    upd_ready = 0;
    for (int i = 0; i < 5; i++) begin
      set_pipe(0, 1, 0, 1'(i), 32'h2000_0000 + 32'(i * 4), 32'h3000_0000 + 32'(i * 16));
      step("r024.fill");
      if (i == 2) check("r024.stall3", 32'(res_stall), 32'd1);
    end
    clear_res();
    upd_ready = 1;
    for (int i = 0; i < 5; i++) step("r024.drain");

    // Reset in the middle of a redirect with 2 queued updates.
    upd_ready = 0;
    set_pipe(0, 1, 0, 0, 32'h4000_0000, 32'h4000_0008);
    set_pipe(1, 1, 1, 1, 32'h4000_0004, 32'h5000_0000);
    step("r025.pre");
    clear_res();
    #2 rst_n = 1'b0;
    #1 check_all_zero("r025");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step("r025.post");

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      rand_res();
      redirect_ready = ($urandom_range(0, 2) != 0);
      upd_ready = 1'($urandom);
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/branch_resolve_ctrl.md
BRANCH_RESOLVE_CTRL -- requirements
Module: branch_resolve_ctrl

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be asynchronous and active-low.
REQ-002 Ports SHALL be, in order:
  clk  in  1  sole clock
  rst_n  in  1  async active-low reset
  res_valid_p[1:0]  in  2  branch-unit result valid, pipe 0 older than pipe 1
  res_is_branch_p[1:0]  in  2  predictor update requested
  res_flush_p[1:0]  in  2  mispredict (direction or target)
  res_taken_p[1:0]  in  2  actual direction
  res_pc_p0/res_pc_p1  in  32 each  branch pc
  res_addr_p0/res_addr_p1  in  32 each  actual next pc (target or pc+8)
  ext_flush  in  1  commit/exception flush, highest priority
  res_stall  out  1  upstream shall hold results
  redirect_valid  out  1  frontend redirect request
  redirect_pc  out  32  redirect address
  redirect_ready  in  1  frontend accepts redirect
  flush_o  out  1  one-cycle backend flush pulse
  upd_valid  out  1  predictor update valid
  upd_pc, upd_target  out  32 each  update contents
  upd_taken  out  1  update direction
  upd_ready  in  1  predictor accepts update
  stat_branch_cnt, stat_mispred_cnt  out  32 each  statistics counters

Function
REQ-003 The FSM SHALL have two states: IDLE (accepting results) and REDIR (redirect pending).
REQ-004 In IDLE, the first mispredicting valid pipe (pipe 0 checked first) SHALL be selected, and any younger pipe-1 result in that cycle SHALL be discarded.
REQ-005 A mispredict selected in cycle N SHALL produce, in cycle N+1, redirect_valid=1, redirect_pc=res_addr of the selected pipe, flush_o=1 for exactly one cycle, and state REDIR.
REQ-006 In REDIR, redirect_valid and redirect_pc SHALL stay stable until the cycle where redirect_ready=1; the FSM SHALL return to IDLE on the following edge.
REQ-007 In REDIR, all res_* inputs SHALL be ignored as wrong-path.
REQ-008 When ext_flush=1, the FSM SHALL go to IDLE next cycle, redirect_valid SHALL drop, the same-cycle res_* SHALL be ignored, and flush_o SHALL NOT be generated.
REQ-009 Each accepted valid result with res_is_branch=1 (pipe 0 first) SHALL enqueue {pc, taken, addr} into a 4-entry update FIFO, including the selected mispredict but not discarded results.
REQ-010 The FIFO SHALL accept 2 enqueues and 1 dequeue per cycle, dequeue on upd_valid&&upd_ready, and present the head with upd_valid=!empty.
REQ-011 res_stall SHALL be combinationally asserted when FIFO occupancy >2 or the state is REDIR.
REQ-012 A result arriving while the FIFO is full SHALL be dropped without corrupting pointers or occupancy.
REQ-013 Same-cycle enqueue and dequeue at full SHALL succeed if the post-dequeue space suffices; pointers SHALL wrap modulo 4.

Reset
REQ-014 While rst_n=0: FSM IDLE; FIFO empty; redirect_valid, flush_o, upd_valid, res_stall = 0; redirect_pc and upd_* data = 0; counters = 0.
REQ-015 Reset asserted mid-REDIR SHALL drop the redirect immediately without emitting flush_o.

Configuration
REQ-016 With BRANCH_STAT_EN defined, stat_branch_cnt SHALL increment per enqueued update and stat_mispred_cnt per selected mispredict, 32-bit wrapping.
REQ-017 Without BRANCH_STAT_EN, both stat outputs SHALL be constant 0 and no counter registers SHALL exist.

Structure
REQ-018 A shared package SHALL hold the FSM state encoding, UPD_FIFO_DEPTH=4, and the update-entry typedef {pc, target, taken}.
REQ-019 The FIFO SHALL be the sub-module branch_upd_fifo (2-write, 1-read); the FSM, selection, and counters SHALL reside in the top.

Verification
REQ-020 Pipe 0 flush=1 with addr=0x1C000100, pipe 1 valid -> next cycle redirect_pc=0x1C000100, flush_o pulse, only the pipe-0 update enqueued.
REQ-021 Pipe 0 correct, pipe 1 flush with addr=0x1C000208 -> two updates enqueued in order, redirect_pc=0x1C000208.
REQ-022 redirect_ready held 0 for 5 cycles -> redirect stable, res_* ignored, flush_o high only in the first cycle.
REQ-023 ext_flush during REDIR -> redirect_valid=0 next cycle, no flush_o, FIFO contents retained.
REQ-024 upd_ready=0 with 5 branches offered -> res_stall at occupancy 3, the fifth result dropped, and 4 updates drained in order once ready.
REQ-025 rst_n pulsed low mid-REDIR with 2 FIFO entries -> all outputs 0, empty FIFO, and counters 0 when BRANCH_STAT_EN is defined.
